// File: rtl/dtw_sched.sv
// dtw_sched: sequencer for the 6-lane DTW distance/compare datapath.
// Walks an N x M DTW matrix in vertical strips of LANES reference columns.
// Each lane follows a skewed wavefront. Per cycle the block drives the datapath
// enable, the base indices, the per-lane neighbour selects and the strip-boundary
// cache port. It also flags the final cell for result capture.
//
// Ports:
//   clk, nrst               clock, asynchronous active-low reset
//   i_start                 start pulse (sampled only when idle)
//   i_tlen / i_rlen         test length N / reference length M (clamped to 32)
//   o_busy, o_done          busy from LOAD through DONE, one-cycle done pulse
//   o_ena                   datapath enable (low flushes the delay register)
//   o_tindex / o_rindex     lane-0 base indices
//   o_sel0/1/2              per-lane diag/up/left select codes, lane 0 in MSBs
//   o_lane_valid            per-lane cell valid, lane 0 is MSB
//   o_ext_left / o_ext_diag lane-0 neighbours taken from the strip cache
//   o_cache_*               strip cache read/write port
//   o_result_valid/_lane    final cell present on datapath D
//
// Optional feature: define DTW_BAND_EN to apply a Sakoe-Chiba band of half-width BAND.
module dtw_sched #(
  parameter int unsigned LANES = 6,
  parameter int unsigned IDXW  = 5,
  parameter int unsigned SELW  = 3,
  parameter int unsigned BAND  = 4
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    i_start,
  input  logic [5:0]              i_tlen,
  input  logic [5:0]              i_rlen,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_ena,
  output logic [IDXW-1:0]         o_tindex,
  output logic [IDXW-1:0]         o_rindex,
  output logic [LANES*SELW-1:0]   o_sel0,
  output logic [LANES*SELW-1:0]   o_sel1,
  output logic [LANES*SELW-1:0]   o_sel2,
  output logic [LANES-1:0]        o_lane_valid,
  output logic                    o_ext_left,
  output logic                    o_ext_diag,
  output logic                    o_cache_re,
  output logic [IDXW-1:0]         o_cache_raddr,
  output logic                    o_cache_we,
  output logic [IDXW-1:0]         o_cache_waddr,
  output logic                    o_result_valid,
  output logic [2:0]              o_result_lane
);

  localparam int unsigned CW  = 6;  // length / wavefront counter width
  localparam int unsigned SW  = 3;  // strip index width
  localparam int unsigned AW  = 7;  // signed cell arithmetic width
  localparam int unsigned SBW = LANES * SELW;
  localparam logic [SELW-1:0] SEL_INF  = SELW'(6);
  localparam logic [SELW-1:0] SEL_ZERO = SELW'(7);
  localparam logic [CW-1:0]   LEN_MAX  = CW'(32);
  localparam logic signed [AW-1:0] ZERO_S = '0;
`ifdef DTW_BAND_EN
  localparam bit BAND_ON = 1'b1;
`else
  localparam bit BAND_ON = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, RUN, GAP, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   k_q, k_d, n_q, n_d, m_q, m_d;
  logic [SW-1:0]   s_q, s_d, slast, ls_cur;
  logic [AW-1:0]   rem;
  logic [CW-1:0]   last_k;

  // Cell (t, r) of lane j for wavefront step k of strip s.
  function automatic logic signed [AW-1:0] cell_t(input logic [CW-1:0] k, input int unsigned j);
    return $signed(AW'(k)) - $signed(AW'(j));
  endfunction

  function automatic logic signed [AW-1:0] cell_r(input logic [SW-1:0] s, input int unsigned j);
    return $signed(AW'(LANES) * AW'(s) + AW'(j));
  endfunction

  function automatic logic cell_ok(input logic signed [AW-1:0] t, input logic signed [AW-1:0] r,
                                   input logic [CW-1:0] n, input logic [CW-1:0] m);
    logic in_band;
    in_band = !BAND_ON || ((t - r) <= $signed(AW'(BAND)) && (r - t) <= $signed(AW'(BAND)));
    return (t >= ZERO_S) && (t < $signed(AW'(n))) && (r < $signed(AW'(m))) && in_band;
  endfunction

  // Last strip index and width-minus-one of the current strip.
  assign slast  = SW'((AW'(m_q) + AW'(LANES - 1)) / AW'(LANES) - AW'(1));
  assign rem    = AW'(m_q) - AW'(1) - AW'(LANES) * AW'(s_q);
  assign ls_cur = (rem > AW'(LANES - 1)) ? SW'(LANES - 1) : SW'(rem);
  assign last_k = n_q - CW'(1) + CW'(ls_cur);

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      k_q     <= '0;
      s_q     <= '0;
      n_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      n_q     <= n_d;
      m_q     <= m_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    n_d     = n_q;
    m_d     = m_q;
    case (state_q)
      IDLE: if (i_start) begin
        n_d     = (i_tlen > LEN_MAX) ? LEN_MAX : i_tlen;
        m_d     = (i_rlen > LEN_MAX) ? LEN_MAX : i_rlen;
        state_d = LOAD;
      end
      LOAD: begin
        k_d     = '0;
        s_d     = '0;
        state_d = (n_q == '0 || m_q == '0) ? DONE : RUN;
      end
      RUN: if (k_q == last_k) begin
        k_d     = '0;
        state_d = (s_q == slast) ? DONE : GAP;
      end else begin
        k_d = k_q + CW'(1);
      end
      GAP: begin
        s_d     = s_q + SW'(1);
        k_d     = '0;
        state_d = RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs for the upcoming cycle, derived from the next state and registered below.
  logic signed [AW-1:0] t_c [LANES];
  logic signed [AW-1:0] r_c [LANES];
  logic [SBW-1:0]       sel0_c, sel1_c, sel2_c;
  logic [LANES-1:0]     lv_c;
  logic [IDXW-1:0]      tidx_c, ridx_c, craddr_c, cwaddr_c;
  logic                 el_c, ed_c, cre_c, cwe_c, ena_c, done_c, rv_c, busy_c;
  logic [2:0]           rl_c;

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      t_c[j] = cell_t(k_d, j);
      r_c[j] = cell_r(s_d, j);
    end
  end

  always_comb begin
    sel0_c   = {LANES{SEL_INF}};
    sel1_c   = {LANES{SEL_INF}};
    sel2_c   = {LANES{SEL_INF}};
    lv_c     = '0;
    tidx_c   = '0;
    ridx_c   = '0;
    el_c     = 1'b0;
    ed_c     = 1'b0;
    cre_c    = 1'b0;
    craddr_c = '0;
    if (state_d == RUN) begin
      tidx_c = (k_d < n_q) ? IDXW'(k_d) : '0;
      ridx_c = IDXW'(AW'(LANES) * AW'(s_d));
      for (int j = 0; j < LANES; j++) begin
        if (cell_ok(t_c[j], r_c[j], n_q, m_q)) begin
          lv_c[LANES-1-j] = 1'b1;
          // Up neighbour lives in the same lane one cycle earlier.
          sel1_c[(LANES-1-j)*SELW +: SELW] = (t_c[j] == ZERO_S) ? SEL_INF : SELW'(j);
          // Left neighbour lives in the lane to the left; lane 0 borrows it from the cache.
          if (r_c[j] != ZERO_S && j > 0)
            sel2_c[(LANES-1-j)*SELW +: SELW] = SELW'(j - 1);
          if (t_c[j] == ZERO_S && r_c[j] == ZERO_S)
            sel0_c[(LANES-1-j)*SELW +: SELW] = SEL_ZERO;
          else if (t_c[j] != ZERO_S && r_c[j] != ZERO_S && j > 0)
            sel0_c[(LANES-1-j)*SELW +: SELW] = SELW'(j - 1);
          if (j == 0) begin
            el_c     = (r_c[j] != ZERO_S);
            ed_c     = (t_c[j] > ZERO_S) && (r_c[j] > ZERO_S);
            cre_c    = (s_d != '0);
            craddr_c = (s_d != '0) ? IDXW'(t_c[j]) : '0;
          end
        end
      end
    end
  end

  // Last lane of a non-final strip hands its column to the cache one cycle later.
  always_comb begin
    cwe_c    = (state_q == RUN) && (s_q < slast) &&
               cell_ok(cell_t(k_q, LANES - 1), cell_r(s_q, LANES - 1), n_q, m_q);
    cwaddr_c = cwe_c ? IDXW'(k_q - CW'(LANES - 1)) : '0;
    busy_c   = (state_d != IDLE);
    done_c   = (state_d == DONE);
    rv_c     = (state_d == DONE) && (state_q == RUN);
    ena_c    = (state_d == RUN) || rv_c;
    rl_c     = rv_c ? 3'(ls_cur) : 3'd0;
  end

  // Output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_ena          <= 1'b0;
      o_tindex       <= '0;
      o_rindex       <= '0;
      o_sel0         <= {LANES{SEL_INF}};
      o_sel1         <= {LANES{SEL_INF}};
      o_sel2         <= {LANES{SEL_INF}};
      o_lane_valid   <= '0;
      o_ext_left     <= 1'b0;
      o_ext_diag     <= 1'b0;
      o_cache_re     <= 1'b0;
      o_cache_raddr  <= '0;
      o_cache_we     <= 1'b0;
      o_cache_waddr  <= '0;
      o_result_valid <= 1'b0;
      o_result_lane  <= '0;
    end else begin
      o_busy         <= busy_c;
      o_done         <= done_c;
      o_ena          <= ena_c;
      o_tindex       <= tidx_c;
      o_rindex       <= ridx_c;
      o_sel0         <= sel0_c;
      o_sel1         <= sel1_c;
      o_sel2         <= sel2_c;
      o_lane_valid   <= lv_c;
      o_ext_left     <= el_c;
      o_ext_diag     <= ed_c;
      o_cache_re     <= cre_c;
      o_cache_raddr  <= craddr_c;
      o_cache_we     <= cwe_c;
      o_cache_waddr  <= cwaddr_c;
      o_result_valid <= rv_c;
      o_result_lane  <= rl_c;
    end
  end

endmodule
